// File: rtl/ex_mem_stage_reg_if.sv
// EX->MEM stage register bundle: EX-side inputs (*_i) and registered MEM-side outputs (*_o).
interface ex_mem_stage_reg_if #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int TNEW_W  = 3
);
  logic               valid_i,     valid_o;
  logic [INSTR_W-1:0] instr_i,     instr_o;
  logic [DATA_W-1:0]  pc_i,        pc_o;
  logic [DATA_W-1:0]  pc8_i,       pc8_o;
  logic [DATA_W-1:0]  rs_val_i,    rs_val_o;
  logic [DATA_W-1:0]  rt_val_i,    rt_val_o;
  logic [DATA_W-1:0]  alu_i,       alu_o;
  logic [DATA_W-1:0]  regdata_i,   regdata_o;
  logic               regwrite_i,  regwrite_o;
  logic               memwrite_i,  memwrite_o;
  logic [4:0]         a3_i,        a3_o;
  logic [4:0]         a2_i,        a2_o;
  logic [4:0]         rd_i,        rd_o;
  logic [TNEW_W-1:0]  tnew_i,      tnew_o;
  logic               exc_valid_i, exc_valid_o;
  logic [4:0]         exc_code_i,  exc_code_o;
  logic               bd_i,        bd_o;
  logic               ov_i, adel_i, ades_i;

  // EX side: drives *_i, observes *_o
  modport master (
    output valid_i, instr_i, pc_i, pc8_i, rs_val_i, rt_val_i, alu_i, regdata_i,
           regwrite_i, memwrite_i, a3_i, a2_i, rd_i, tnew_i, exc_valid_i,
           exc_code_i, bd_i, ov_i, adel_i, ades_i,
    input  valid_o, instr_o, pc_o, pc8_o, rs_val_o, rt_val_o, alu_o, regdata_o,
           regwrite_o, memwrite_o, a3_o, a2_o, rd_o, tnew_o, exc_valid_o,
           exc_code_o, bd_o
  );

  // Stage register: consumes *_i, owns *_o
  modport slave (
    input  valid_i, instr_i, pc_i, pc8_i, rs_val_i, rt_val_i, alu_i, regdata_i,
           regwrite_i, memwrite_i, a3_i, a2_i, rd_i, tnew_i, exc_valid_i,
           exc_code_i, bd_i, ov_i, adel_i, ades_i,
    output valid_o, instr_o, pc_o, pc8_o, rs_val_o, rt_val_o, alu_o, regdata_o,
           regwrite_o, memwrite_o, a3_o, a2_o, rd_o, tnew_o, exc_valid_o,
           exc_code_o, bd_o
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with stall hold, bubble/flush insertion, exception
// merging (upstream > ov > adel > ades), side-effect kill and tnew countdown.
module ex_mem_stage_reg #(
  parameter int          INSTR_W   = 32,
  parameter int          DATA_W    = 32,
  parameter int          TNEW_W    = 3,
  parameter logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               reset,
  input logic               stall,
  input logic               bubble,
  input logic               flush,
  input logic               eret,
  ex_mem_stage_reg_if.slave bus
);

  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic              exc_valid;
  logic [4:0]        exc_code;
  logic [TNEW_W-1:0] tnew_dec;

  // Merge in-flight and EX-detected exceptions; an invalid slot reports none.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    if (bus.valid_i) begin
      exc_valid = bus.exc_valid_i | bus.ov_i | bus.adel_i | bus.ades_i;
      if      (bus.exc_valid_i) exc_code = bus.exc_code_i;
      else if (bus.ov_i)        exc_code = EXC_OV;
      else if (bus.adel_i)      exc_code = EXC_ADEL;
      else if (bus.ades_i)      exc_code = EXC_ADES;
    end
  end

  // tnew is measured in EX; one stage later it is one less, saturating at 0.
  always_comb begin
    tnew_dec = '0;
    if (bus.tnew_i != '0) tnew_dec = bus.tnew_i - 1'b1;
  end

  // Stage update: reset > flush/eret > stall > bubble > load.
  always_ff @(posedge clk) begin
    if (reset || flush || eret || (bubble && !stall)) begin
      bus.valid_o     <= 1'b0;
      bus.instr_o     <= '0;
      bus.pc_o        <= BUBBLE_PC[DATA_W-1:0];
      bus.pc8_o       <= '0;
      bus.rs_val_o    <= '0;
      bus.rt_val_o    <= '0;
      bus.alu_o       <= '0;
      bus.regdata_o   <= '0;
      bus.regwrite_o  <= 1'b0;
      bus.memwrite_o  <= 1'b0;
      bus.a3_o        <= '0;
      bus.a2_o        <= '0;
      bus.rd_o        <= '0;
      bus.tnew_o      <= '0;
      bus.exc_valid_o <= 1'b0;
      bus.exc_code_o  <= '0;
      bus.bd_o        <= 1'b0;
    end else if (!stall) begin
      bus.valid_o     <= bus.valid_i;
      bus.instr_o     <= bus.instr_i;
      bus.pc_o        <= bus.pc_i;
      bus.pc8_o       <= bus.pc8_i;
      bus.rs_val_o    <= bus.rs_val_i;
      bus.rt_val_o    <= bus.rt_val_i;
      bus.alu_o       <= bus.alu_i;
      bus.regdata_o   <= bus.regdata_i;
      // excepting instructions must not write back or store
      bus.regwrite_o  <= bus.regwrite_i & ~exc_valid;
      bus.memwrite_o  <= bus.memwrite_i & ~exc_valid;
      bus.a3_o        <= bus.a3_i;
      bus.a2_o        <= bus.a2_i;
      bus.rd_o        <= bus.rd_i;
      bus.tnew_o      <= tnew_dec;
      bus.exc_valid_o <= exc_valid;
      bus.exc_code_o  <= exc_code;
      bus.bd_o        <= bus.bd_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg with hand-computed expectations.
module tb_ex_mem_stage_reg;
  logic clk = 1'b0;
  logic reset, stall, bubble, flush, eret;
  int checks = 0;
  int failures = 0;

  ex_mem_stage_reg_if #(.INSTR_W(32), .DATA_W(32), .TNEW_W(3)) bus ();

  ex_mem_stage_reg #(.INSTR_W(32), .DATA_W(32), .TNEW_W(3), .BUBBLE_PC(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .flush(flush), .eret(eret), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reset = 0; stall = 0; bubble = 0; flush = 0; eret = 0;
    bus.valid_i = 0; bus.instr_i = '0; bus.pc_i = '0; bus.pc8_i = '0;
    bus.rs_val_i = '0; bus.rt_val_i = '0; bus.alu_i = '0; bus.regdata_i = '0;
    bus.regwrite_i = 0; bus.memwrite_i = 0; bus.a3_i = '0; bus.a2_i = '0;
    bus.rd_i = '0; bus.tnew_i = '0; bus.exc_valid_i = 0; bus.exc_code_i = '0;
    bus.bd_i = 0; bus.ov_i = 0; bus.adel_i = 0; bus.ades_i = 0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".pc"}, bus.pc_o, 32'hFFFF_FFFF);
    chk({tag, ".valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, ".rw_mw"}, {30'd0, bus.regwrite_o, bus.memwrite_o}, 32'd0);
    chk({tag, ".alu"}, bus.alu_o, 32'd0);
    chk({tag, ".tnew_exc_bd"}, {25'd0, bus.tnew_o, bus.exc_valid_o, bus.exc_code_o, bus.bd_o}, 32'd0);
  endtask

  initial begin
    clear_in();
    #1;
    // reset
    reset = 1; tick(); reset = 0;
    chk_bubble("reset");
    chk("reset.a3_rd", {22'd0, bus.a3_o, bus.rd_o}, 32'd0);

    // basic load
    bus.valid_i = 1; bus.pc_i = 32'h3000; bus.alu_i = 32'h1234;
    bus.regwrite_i = 1; bus.a3_i = 5'd8; bus.tnew_i = 3'd2;
    bus.rd_i = 5'd12; bus.pc8_i = 32'h3008; bus.instr_i = 32'hDEAD_BEEF;
    tick();
    chk("load.pc", bus.pc_o, 32'h3000);
    chk("load.alu", bus.alu_o, 32'h1234);
    chk("load.regwrite", {31'd0, bus.regwrite_o}, 32'd1);
    chk("load.a3", {27'd0, bus.a3_o}, 32'd8);
    chk("load.tnew", {29'd0, bus.tnew_o}, 32'd1);
    chk("load.valid", {31'd0, bus.valid_o}, 32'd1);
    chk("load.rd", {27'd0, bus.rd_o}, 32'd12);
    chk("load.pc8", bus.pc8_o, 32'h3008);
    chk("load.instr", bus.instr_o, 32'hDEAD_BEEF);

    // tnew saturation
    bus.tnew_i = 3'd0; tick();
    chk("tnew0", {29'd0, bus.tnew_o}, 32'd0);
    bus.tnew_i = 3'd7; tick();
    chk("tnew7", {29'd0, bus.tnew_o}, 32'd6);

    // stall hold
    bus.pc_i = 32'h3004; bus.alu_i = 32'hAAAA; bus.tnew_i = 3'd3; tick();
    chk("pre_stall.tnew", {29'd0, bus.tnew_o}, 32'd2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_i = 32'h5000 + i; bus.alu_i = 32'h7777 + i; bus.tnew_i = 3'd3;
      bus.regwrite_i = 0; bus.valid_i = 0;
      tick();
      chk("stall.pc", bus.pc_o, 32'h3004);
      chk("stall.alu", bus.alu_o, 32'hAAAA);
      chk("stall.tnew", {29'd0, bus.tnew_o}, 32'd2);
      chk("stall.valid_rw", {30'd0, bus.valid_o, bus.regwrite_o}, 32'd3);
    end
    bubble = 1; tick();
    chk("stall_bubble.pc", bus.pc_o, 32'h3004);
    chk("stall_bubble.valid", {31'd0, bus.valid_o}, 32'd1);
    stall = 0; tick(); bubble = 0;
    chk_bubble("bubble");

    // reset mid-stall
    bus.valid_i = 1; bus.pc_i = 32'h3010; bus.regwrite_i = 1; tick();
    chk("reload.pc", bus.pc_o, 32'h3010);
    stall = 1; tick();
    reset = 1; tick(); reset = 0;
    chk_bubble("reset_stall");

    // flush + stall
    stall = 0; bus.memwrite_i = 1; bus.pc_i = 32'h3020; tick();
    chk("pre_flush.rw_mw", {30'd0, bus.regwrite_o, bus.memwrite_o}, 32'd3);
    stall = 1; flush = 1; tick(); flush = 0;
    chk_bubble("flush");
    // eret + stall
    stall = 0; tick();
    chk("pre_eret.pc", bus.pc_o, 32'h3020);
    stall = 1; eret = 1; tick(); eret = 0; stall = 0;
    chk_bubble("eret");

    // exception priority
    bus.valid_i = 1; bus.regwrite_i = 1; bus.memwrite_i = 0; bus.pc_i = 32'h3040;
    bus.exc_valid_i = 1; bus.exc_code_i = 5'd10; bus.ov_i = 1; tick();
    chk("exc_up.code", {27'd0, bus.exc_code_o}, 32'd10);
    chk("exc_up.valid", {31'd0, bus.exc_valid_o}, 32'd1);
    chk("exc_up.regwrite", {31'd0, bus.regwrite_o}, 32'd0);
    chk("exc_up.pc", bus.pc_o, 32'h3040);
    bus.exc_valid_i = 0; bus.exc_code_i = 5'd0; tick();
    chk("exc_ov.code", {26'd0, bus.exc_valid_o, bus.exc_code_o}, 32'h2C);
    bus.ov_i = 0; bus.adel_i = 1; bus.ades_i = 1; tick();
    chk("exc_adel.code", {26'd0, bus.exc_valid_o, bus.exc_code_o}, 32'h24);
    bus.adel_i = 0; bus.memwrite_i = 1; bus.regwrite_i = 0; bus.alu_i = 32'hBAD0_0001;
    bus.bd_i = 1; tick();
    chk("exc_ades.code", {26'd0, bus.exc_valid_o, bus.exc_code_o}, 32'h25);
    chk("exc_ades.memwrite", {31'd0, bus.memwrite_o}, 32'd0);
    chk("exc_ades.alu", bus.alu_o, 32'hBAD0_0001);
    chk("exc_ades.bd", {31'd0, bus.bd_o}, 32'd1);
    // no exception: writes pass through
    bus.ades_i = 0; bus.regwrite_i = 1; bus.bd_i = 0; tick();
    chk("noexc.rw_mw_exc", {29'd0, bus.regwrite_o, bus.memwrite_o, bus.exc_valid_o}, 32'd6);

    // invalid slot
    bus.valid_i = 0; bus.ov_i = 1; bus.bd_i = 1; bus.exc_valid_i = 1; bus.exc_code_i = 5'd7;
    tick();
    chk("inval.exc", {26'd0, bus.exc_valid_o, bus.exc_code_o}, 32'd0);
    chk("inval.bd_valid", {30'd0, bus.bd_o, bus.valid_o}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX→MEM pipeline register for the MIPS pipeline.
- Registers all EX results and control fields, including the register-write, memory-write and dest/src/rd fields (`rd_o` feeds CP0 `mtc0`/`mfc0`).
- Adds what the previous stage register lacked: stall hold, explicit bubble insertion, a valid bit, and prioritised merging of in-flight and EX-detected exceptions into one code.
- Also suppresses side effects of excepting instructions and counts down `tnew` for the hazard unit.

Parameters:
INSTR_W, 32, width of decoded instruction bus
DATA_W, 32, datapath width
TNEW_W, 3, width of tnew field
BUBBLE_PC, 32'hFFFF_FFFF, pc_o value loaded for a bubble/flush

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stall  in  1  hold current contents
bubble  in  1  load a bubble instead of inputs (ignored while stall=1)
flush  in  1  exception taken in MEM; kill this stage's next content
eret  in  1  eret in MEM; same effect as flush
valid_i  in  1  incoming instruction is real
instr_i  in  INSTR_W  decoded instruction bus
pc_i  in  DATA_W  instruction pc
pc8_i  in  DATA_W  pc+8 link value
rs_val_i, rt_val_i, alu_i, regdata_i  in  DATA_W  operands / ALU result / forwarded write data
regwrite_i, memwrite_i  in  1  write enables
a3_i, a2_i, rd_i  in  5  dest reg / rt index / rd index
tnew_i  in  TNEW_W  cycles until result available, measured in EX
exc_valid_i  in  1  exception already flagged upstream
exc_code_i  in  5  its ExcCode
bd_i  in  1  instruction sits in a delay slot
ov_i, adel_i, ades_i  in  1  EX-detected overflow / load-address / store-address errors
valid_o, instr_o, pc_o, pc8_o, rs_val_o, rt_val_o, alu_o, regdata_o, regwrite_o, memwrite_o, a3_o, a2_o, rd_o, tnew_o, exc_valid_o, exc_code_o, bd_o  out  (widths as inputs)  registered copies

Behaviour:
- Single clock. All updates occur on posedge `clk`. Outputs are direct flops; latency is 1 cycle.
- Update priority, evaluated per edge: `reset` > (`flush` | `eret`) > `stall` > `bubble` > load.
- **Bubble state**, loaded by `reset`, `flush`, `eret`, or `bubble` without `stall`:
  - `pc_o` = `BUBBLE_PC`.
  - Every other output = 0, including `valid_o`, `regwrite_o`, `memwrite_o`, `exc_valid_o`, `bd_o` and `tnew_o`.
- **Stall:** every output holds its value, including `tnew_o` (no countdown while held). `flush`/`eret` override `stall`.
- **Load:**
  - Fields are copied from the inputs.
  - `valid_o` = `valid_i`.
  - `tnew_o` = `tnew_i` − 1 if `tnew_i` > 0, else 0. It saturates at 0 and never wraps.
- **Exception merge on load**, first match wins:
  1. `exc_valid_i` → `exc_code_i` (upstream exceptions are older: AdEL on fetch, RI).
  2. `ov_i` → 12.
  3. `adel_i` → 4.
  4. `ades_i` → 5.
  - `exc_valid_o` = any of these four sources, gated by `valid_i`.
  - If `valid_i` = 0: `exc_valid_o` = 0, `exc_code_o` = 0, and EX flags are ignored.
- **Side-effect kill on load:**
  - If the merged exception is valid, `regwrite_o` = 0 and `memwrite_o` = 0.
  - `pc_o`, `bd_o` and `alu_o` are still loaded, so CP0 gets EPC/BadVAddr.
- `bd_o` is loaded from `bd_i` even when `exc_valid_o` = 1.
- Simultaneous `bubble` + `stall`: `stall` wins (hold).
- Simultaneous `flush` + `stall`: bubble.
- `reset` mid-stall: bubble next edge.
- No internal state beyond the output flops. No combinational path from any input to any output.

Test Plan:
- **Reset then load.** Assert `reset` 1 cycle → `pc_o`=FFFF_FFFF, `valid_o`=0, all others 0. Then load `valid_i`=1, `pc_i`=0x3000, `alu_i`=0x1234, `regwrite_i`=1, `a3_i`=8, `tnew_i`=2 → next cycle `pc_o`=0x3000, `alu_o`=0x1234, `regwrite_o`=1, `a3_o`=8, `tnew_o`=1.
- **tnew saturation.** `tnew_i`=0 → `tnew_o`=0. `tnew_i`=7 → `tnew_o`=6.
- **Stall.** Load `pc_i`=0x3004, then `stall`=1 for 3 cycles with changing inputs and `tnew_i`=3 → outputs frozen at the 0x3004 contents. `tnew_o` unchanged. `stall`+`bubble` also holds.
- **Flush/eret.** `flush`=1 with `stall`=1 and valid inputs → `pc_o`=FFFF_FFFF, `valid_o`=0, `regwrite_o`=0, `memwrite_o`=0. Repeat with `eret` → same result.
- **Exception priority.**
  - `exc_valid_i`=1, code 10, `ov_i`=1 → `exc_code_o`=10, `exc_valid_o`=1, `regwrite_o`=0.
  - Only `ov_i` → 12.
  - `adel_i`+`ades_i` → 4.
  - `ades_i` with `memwrite_i`=1 → code 5, `memwrite_o`=0, `alu_o` still loaded.
- **Invalid slot.** `valid_i`=0 with `ov_i`=1 and `bd_i`=1 → `exc_valid_o`=0, `exc_code_o`=0, `bd_o`=1, `valid_o`=0.
